// File: rtl/bnn_pkg.sv
// Shared defaults, width derivations and popcount helper for the binary XNOR engine.
package bnn_pkg;

   localparam int KW_DEF        = 7;
   localparam int NCH_DEF       = 7;
   localparam int MAX_BEATS_DEF = 16;
   localparam int POP_MAX       = 64;

   function automatic int acc_w(input int beats, input int kw);
      return $clog2(beats * kw + 1) + 1;
   endfunction

   function automatic int cnt_w(input int beats);
      return $clog2(beats + 1);
   endfunction

   function automatic int addr_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int popcount(input logic [POP_MAX-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// One channel's signed XNOR-popcount contribution: 2*popcount(~(x^w)) - KW, purely combinational.
module bnn_xnor_popcount
   import bnn_pkg::*;
#(
   parameter int KW    = KW_DEF,
   parameter int ACC_W = acc_w(MAX_BEATS_DEF, KW_DEF)
) (
   input  logic [KW-1:0]           in_data,
   input  logic [KW-1:0]           weight,
   output logic signed [ACC_W-1:0] contrib
);

   logic [POP_MAX-1:0] match_ext;

   // NOTE: every variable written in always_comb is given a value first, so no path can infer a latch.
   always_comb begin
      match_ext          = '0;
      match_ext[KW-1:0]  = ~(in_data ^ weight);
      contrib            = ACC_W'(2 * popcount(match_ext) - KW);
   end

endmodule

// File: rtl/bnn_xnor_engine.sv
// Binary-NN XNOR/popcount accumulator: NCH channels, windowed beats, one registered result per window.
// Define BNN_THRESH_EN to add per-channel writable thresholds for out_bits (otherwise the threshold is 0).
module bnn_xnor_engine
   import bnn_pkg::*;
#(
   parameter int KW        = KW_DEF,
   parameter int NCH       = NCH_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int ACC_W     = acc_w(MAX_BEATS, KW),
   parameter int CNT_W     = cnt_w(MAX_BEATS),
   parameter int AW        = addr_w(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   w_we,
   input  logic [AW-1:0]          w_addr,
   input  logic [KW-1:0]          w_data,
   input  logic                   th_we,
   input  logic [ACC_W-1:0]       th_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [KW-1:0]          in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NCH*ACC_W-1:0]   out_acc,
   output logic [NCH-1:0]         out_bits,
   output logic [CNT_W-1:0]       out_count,
   output logic                   out_ovf
);

   logic [KW-1:0]           w_q [NCH];
   logic [KW-1:0]           w_d [NCH];
   logic signed [ACC_W-1:0] acc_q [NCH];
   logic signed [ACC_W-1:0] acc_d [NCH];
   logic signed [ACC_W-1:0] out_acc_q [NCH];
   logic signed [ACC_W-1:0] out_acc_d [NCH];
   logic signed [ACC_W-1:0] contrib [NCH];
   logic signed [ACC_W-1:0] sum_v [NCH];
   logic signed [ACC_W-1:0] thr_eff [NCH];
   logic [NCH-1:0]          hit_v;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        out_count_q, out_count_d;
   logic [NCH-1:0]          out_bits_q, out_bits_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    accept, close;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      bnn_xnor_popcount #(.KW(KW), .ACC_W(ACC_W)) u_popcount (
         .in_data (in_data),
         .weight  (w_q[g]),
         .contrib (contrib[g])
      );
      assign out_acc[g*ACC_W +: ACC_W] = out_acc_q[g];
   end

`ifdef BNN_THRESH_EN
   logic signed [ACC_W-1:0] thr_q [NCH];
   logic signed [ACC_W-1:0] thr_d [NCH];

   always_comb begin
      thr_d = thr_q;
      if (th_we && int'(w_addr) < NCH) thr_d[w_addr] = th_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) thr_q[c] <= '0;
      end else begin
         thr_q <= thr_d;
      end
   end

   always_comb thr_eff = thr_q;
`else
   logic unused_thr;
   assign unused_thr = ^{th_we, th_data};

   always_comb begin
      for (int c = 0; c < NCH; c++) thr_eff[c] = '0;
   end
`endif

   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_bits  = out_bits_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

   always_comb begin
      accept = in_valid && in_ready && !clr;
      close  = accept && (in_last || cnt_q == CNT_W'(MAX_BEATS - 1));

      w_d         = w_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_acc_d   = out_acc_q;
      out_bits_d  = out_bits_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;

      for (int c = 0; c < NCH; c++) begin
         sum_v[c] = acc_q[c] + contrib[c];
         hit_v[c] = sum_v[c] >= thr_eff[c];
      end

      // Beats use the pre-edge weights; a write here only affects later beats.
      if (w_we && int'(w_addr) < NCH) w_d[w_addr] = w_data;

      if (clr) begin
         for (int c = 0; c < NCH; c++) acc_d[c] = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else if (close) begin
         for (int c = 0; c < NCH; c++) acc_d[c] = '0;
         cnt_d       = '0;
         out_acc_d   = sum_v;
         out_bits_d  = hit_v;
         out_count_d = cnt_q + CNT_W'(1);
         out_ovf_d   = !in_last;
         out_valid_d = 1'b1;
      end else begin
         if (accept) begin
            acc_d = sum_v;
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (out_valid_q && out_ready) out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: weight storage is reset as well; zero weights are the defined power-up state.
         for (int c = 0; c < NCH; c++) begin
            w_q[c]       <= '0;
            acc_q[c]     <= '0;
            out_acc_q[c] <= '0;
         end
         cnt_q       <= '0;
         out_bits_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         w_q         <= w_d;
         acc_q       <= acc_d;
         out_acc_q   <= out_acc_d;
         cnt_q       <= cnt_d;
         out_bits_q  <= out_bits_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_bnn_xnor_engine.sv
// Self-checking bench for bnn_xnor_engine: vector table, directed corner sequences, randomized run vs model.
module tb_bnn_xnor_engine;

   localparam int KW        = 7;
   localparam int NCH       = 7;
   localparam int MAX_BEATS = 4;
   localparam int ACC_W     = $clog2(MAX_BEATS * KW + 1) + 1;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);
   localparam int AW        = $clog2(NCH);
   localparam logic [NCH-1:0] ALL_ONES = '1;

   logic                 clk = 1'b0;
   logic                 rst, clr, w_we, th_we;
   logic [AW-1:0]        w_addr;
   logic [KW-1:0]        w_data, in_data;
   logic [ACC_W-1:0]     th_data;
   logic                 in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [NCH*ACC_W-1:0] out_acc;
   logic [NCH-1:0]       out_bits;
   logic [CNT_W-1:0]     out_count;

   int n_checks = 0;
   int n_errors = 0;

   bnn_xnor_engine #(.KW(KW), .NCH(NCH), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .th_we(th_we), .th_data(th_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_bits(out_bits), .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   logic [KW-1:0]  w_m [NCH];
   int             thr_m [NCH];
   int             acc_m [NCH];
   int             cnt_m;
   bit             r_valid;
   int             r_acc [NCH];
   logic [NCH-1:0] r_bits;
   int             r_cnt;
   bit             r_ovf;

   function automatic int contrib_of(input logic [KW-1:0] x, input logic [KW-1:0] w);
      logic [KW-1:0] same;
      same = ~(x ^ w);
      return 2 * $countones(same) - KW;
   endfunction

   function automatic int thr_of(input int c);
`ifdef BNN_THRESH_EN
      return thr_m[c];
`else
      return 0 * c;
`endif
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         w_m[c] = '0; thr_m[c] = 0; acc_m[c] = 0; r_acc[c] = 0;
      end
      cnt_m = 0; r_valid = 0; r_bits = '0; r_cnt = 0; r_ovf = 0;
   endtask

   // Advances the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit ready, took;
      ready = !r_valid || out_ready;
      took  = in_valid && ready && !clr;
      if (clr) begin
         for (int c = 0; c < NCH; c++) acc_m[c] = 0;
         cnt_m = 0; r_valid = 0;
      end else begin
         if (r_valid && out_ready) r_valid = 0;
         if (took) begin
            for (int c = 0; c < NCH; c++) acc_m[c] += contrib_of(in_data, w_m[c]);
            cnt_m++;
            if (in_last || cnt_m == MAX_BEATS) begin
               for (int c = 0; c < NCH; c++) begin
                  r_acc[c]  = acc_m[c];
                  r_bits[c] = (acc_m[c] >= thr_of(c));
                  acc_m[c]  = 0;
               end
               r_cnt = cnt_m; r_ovf = !in_last; r_valid = 1; cnt_m = 0;
            end
         end
      end
      if (w_we && int'(w_addr) < NCH) w_m[w_addr] = w_data;
      if (th_we && int'(w_addr) < NCH) thr_m[w_addr] = int'($signed(th_data));
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [31:0] acc_of(input int c);
      return $signed(out_acc[c*ACC_W +: ACC_W]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_w(input int addr, input logic [KW-1:0] d);
      w_we = 1; w_addr = AW'(addr); w_data = d;
      tick();
      w_we = 0;
   endtask

   task automatic write_th(input int addr, input int t);
      th_we = 1; w_addr = AW'(addr); th_data = ACC_W'(t);
      tick();
      th_we = 0;
   endtask

   task automatic beat(input logic [KW-1:0] d, input logic last);
      in_valid = 1; in_data = d; in_last = last;
      tick();
      in_valid = 0; in_last = 0;
   endtask

   task automatic check_result(input string name, input int exp_acc, input int exp_cnt,
                               input logic exp_ovf, input logic [NCH-1:0] exp_bits);
      check({name, " out_valid"}, out_valid, 1);
      for (int c = 0; c < NCH; c++) check($sformatf("%s acc[%0d]", name, c), acc_of(c), exp_acc);
      check({name, " count"}, out_count, exp_cnt);
      check({name, " ovf"}, out_ovf, exp_ovf);
      check({name, " bits"}, out_bits, exp_bits);
   endtask

   typedef struct {
      logic [KW-1:0] w0;
      logic [KW-1:0] w_rest;
      logic [KW-1:0] din;
      int            exp0;
      int            exp_rest;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic           rb;
      logic [NCH-1:0] exp_bits;
      int             t;

      vecs[0] = '{w0: 7'h00, w_rest: 7'h7F, din: 7'h7F, exp0: -7, exp_rest:  7};
      vecs[1] = '{w0: 7'h00, w_rest: 7'h00, din: 7'h00, exp0:  7, exp_rest:  7};
      vecs[2] = '{w0: 7'h7F, w_rest: 7'h00, din: 7'h00, exp0: -7, exp_rest:  7};
      vecs[3] = '{w0: 7'h0F, w_rest: 7'h70, din: 7'h0F, exp0:  7, exp_rest: -7};
      vecs[4] = '{w0: 7'h55, w_rest: 7'h2A, din: 7'h7F, exp0:  1, exp_rest: -1};
      vecs[5] = '{w0: 7'h01, w_rest: 7'h03, din: 7'h00, exp0:  5, exp_rest:  3};

      rst = 1; clr = 0; w_we = 0; th_we = 0; w_addr = '0; w_data = '0; th_data = '0;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;

      // Reset state
      tick(); tick();
      check("reset out_valid", out_valid, 0);
      check("reset in_ready", in_ready, 1);
      check("reset out_acc0", acc_of(0), 0);
      check("reset out_bits", out_bits, 0);
      check("reset out_count", out_count, 0);
      check("reset out_ovf", out_ovf, 0);
      rst = 0;
      tick();

      // Single-beat windows from the vector table
      for (int v = 0; v < 6; v++) begin
         write_w(0, vecs[v].w0);
         for (int c = 1; c < NCH; c++) write_w(c, vecs[v].w_rest);
         beat(vecs[v].din, 1);
         rb = (vecs[v].exp_rest >= 0);
         exp_bits = {{(NCH-1){rb}}, (vecs[v].exp0 >= 0)};
         check($sformatf("vec%0d out_valid", v), out_valid, 1);
         for (int c = 0; c < NCH; c++)
            check($sformatf("vec%0d acc[%0d]", v, c), acc_of(c), (c == 0) ? vecs[v].exp0 : vecs[v].exp_rest);
         check($sformatf("vec%0d bits", v), out_bits, exp_bits);
         check($sformatf("vec%0d count", v), out_count, 1);
      end

      // Three-beat window, latency one cycle after the last beat
      for (int c = 0; c < NCH; c++) write_w(c, 7'h7F);
      beat(7'h7F, 0);
      check("win3 valid after beat1", out_valid, 0);
      beat(7'h7F, 0);
      check("win3 valid after beat2", out_valid, 0);
      beat(7'h7F, 1);
      check_result("win3", 21, 3, 0, ALL_ONES);
      tick();
      check("win3 valid drop", out_valid, 0);

      // Back-pressure: result held while out_ready=0
      out_ready = 0;
      beat(7'h7F, 1);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1; in_data = 7'h00; in_last = 1;
         #1;
         check($sformatf("stall%0d in_ready", k), in_ready, 0);
         tick();
         check($sformatf("stall%0d out_valid", k), out_valid, 1);
         check($sformatf("stall%0d acc0", k), acc_of(0), 7);
         check($sformatf("stall%0d acc6", k), acc_of(NCH-1), 7);
         check($sformatf("stall%0d count", k), out_count, 1);
      end
      out_ready = 1; in_valid = 1; in_data = 7'h7F; in_last = 0;
      #1;
      check("release in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      check("release valid drop", out_valid, 0);
      beat(7'h7F, 1);
      check_result("release", 14, 2, 0, ALL_ONES);

      // Forced close at MAX_BEATS, next beat opens a new window while the result drains
      for (int k = 0; k < MAX_BEATS - 1; k++) begin
         beat(7'h7F, 0);
         check($sformatf("ovf beat%0d valid", k), out_valid, 0);
      end
      beat(7'h7F, 0);
      check_result("ovf close", 28, 4, 1, ALL_ONES);
      in_valid = 1; in_data = 7'h7F; in_last = 0;
      #1;
      check("ovf beat5 in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      check("ovf beat5 valid", out_valid, 0);
      beat(7'h7F, 1);
      check_result("ovf next", 14, 2, 0, ALL_ONES);

      // Synchronous clear beats a simultaneous beat and drops the partial sum
      beat(7'h7F, 0);
      beat(7'h7F, 0);
      clr = 1; in_valid = 1; in_data = 7'h00; in_last = 1;
      tick();
      clr = 0; in_valid = 0; in_last = 0;
      check("clr valid", out_valid, 0);
      beat(7'h7F, 1);
      check_result("after clr", 7, 1, 0, ALL_ONES);
      for (int c = 0; c < NCH; c++) write_th(c, 8);
      beat(7'h7F, 1);
`ifdef BNN_THRESH_EN
      exp_bits = '0;
`else
      exp_bits = ALL_ONES;
`endif
      check_result("thresh8", 7, 1, 0, exp_bits);
      out_ready = 0;
      clr = 1;
      tick();
      clr = 0;
      check("clr pending valid", out_valid, 0);
      check("clr pending in_ready", in_ready, 1);
      out_ready = 1;

      // Asynchronous reset mid-window
      beat(7'h7F, 0);
      beat(7'h7F, 0);
      rst = 1;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst in_ready", in_ready, 1);
      check("midrst acc0", acc_of(0), 0);
      check("midrst count", out_count, 0);
      tick();
      rst = 0;
      tick();
      beat(7'h00, 1);
      check_result("post rst", 7, 1, 0, ALL_ONES);

      // Randomized run against the model
      rst = 1;
      tick();
      rst = 0;
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = KW'($urandom);
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         w_we      = ($urandom_range(0, 7) == 0);
         w_addr    = AW'($urandom_range(0, 7));
         w_data    = KW'($urandom);
         th_we     = ($urandom_range(0, 7) == 0);
         t         = int'($urandom_range(0, 20)) - 10;
         th_data   = ACC_W'(t);
         clr       = ($urandom_range(0, 63) == 0);
         #1;
         check("rnd in_ready", in_ready, (!r_valid || out_ready));
         model_step();
         tick();
         check("rnd out_valid", out_valid, r_valid);
         if (r_valid) begin
            for (int c = 0; c < NCH; c++) check($sformatf("rnd acc[%0d]", c), acc_of(c), r_acc[c]);
            check("rnd bits", out_bits, r_bits);
            check("rnd count", out_count, r_cnt);
            check("rnd ovf", out_ovf, r_ovf);
         end
      end
      in_valid = 0; w_we = 0; th_we = 0; clr = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bnn_xnor_engine.md
BNN_XNOR_ENGINE -- requirements
Module: bnn_xnor_engine

Interface
REQ-001 Parameter KW, default 7, sets binary activation/weight vector width in bits.
REQ-002 Parameter NCH, default 7, sets output channel count, one weight vector per channel.
REQ-003 Parameter MAX_BEATS, default 16, sets maximum beats per accumulation window.
REQ-004 Derived ACC_W = clog2(MAX_BEATS*KW+1)+1 (signed), CNT_W = clog2(MAX_BEATS+1), AW = clog2(NCH).
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port clr, input, 1, synchronous clear of accumulators, beat count and pending output.
REQ-008 Ports w_we input 1, w_addr input AW, w_data input KW: write the weight vector of channel w_addr.
REQ-009 Ports th_we input 1, th_data input ACC_W signed: write the threshold of channel w_addr.
REQ-010 Ports in_valid input 1, in_ready output 1, in_data input KW, in_last input 1: activation beat stream.
REQ-011 Ports out_valid output 1, out_ready input 1: result handshake.
REQ-012 Port out_acc, output, NCH*ACC_W, signed per-channel sums, channel 0 in the LSBs.
REQ-013 Ports out_bits output NCH, out_count output CNT_W, out_ovf output 1: activations, beats in window, forced-close flag.

Function
REQ-014 Beat accepted when in_valid && in_ready; per channel c, contribution = 2*popcount(~(in_data ^ w[c])) - KW, range -KW..+KW.
REQ-015 Each accepted beat adds its contribution to acc[c] and increments beat count, using weights as registered before that edge.
REQ-016 A write to the weight of channel c in the same cycle as a beat accept takes effect from the next beat; other channels are unaffected.
REQ-017 Window closes on an accepted beat with in_last=1, or on the MAX_BEATS-th beat without in_last; the latter sets out_ovf=1.
REQ-018 On close: result register loads acc+contribution, final count and ovf; out_valid=1 the next cycle (latency 1); acc and count go to 0.
REQ-019 in_ready = !out_valid || out_ready; a new window may start the same cycle the previous result is consumed.
REQ-020 While out_valid && !out_ready: out_acc, out_bits, out_count and out_ovf are held stable and in_ready=0.
REQ-021 out_valid falls the cycle after out_valid && out_ready, unless a new close occurs in that cycle.
REQ-022 clr has priority over beat acceptance: acc, count and out_valid go to 0; weights and thresholds are retained.
REQ-023 Accumulation is exact; ACC_W guarantees no wrap for any window of up to MAX_BEATS beats.

Reset
REQ-024 While rst=1: acc=0, count=0, out_valid=0, out_acc=0, out_bits=0, out_count=0, out_ovf=0, and in_ready=1.
REQ-025 Reset also clears all weights to 0 and all thresholds to 0; rst mid-window discards the partial sum.

Configuration
REQ-026 Macro BNN_THRESH_EN, when defined: out_bits[c] = (out_acc[c] >= thr[c]), thresholds are writable via th_we.
REQ-027 When BNN_THRESH_EN is undefined: no threshold storage, th_we/th_data are ignored, out_bits[c] = (out_acc[c] >= 0).

Structure
REQ-028 Package bnn_pkg holds the KW/NCH/MAX_BEATS defaults, the ACC_W/CNT_W derivation functions and a popcount function.
REQ-029 Sub-module bnn_xnor_popcount computes one channel's signed contribution combinationally and is instantiated NCH times.

Verification
REQ-030 Reset: assert rst mid-window -> out_valid=0, in_ready=1, next 1-beat window with w=0, in=0 gives +7 on every channel.
REQ-031 All weights 7'h7F, three beats of 7'h7F with in_last on beat 3 -> out_acc=21 on every channel, out_count=3, out_ovf=0, one cycle after beat 3.
REQ-032 w[0]=7'h00, all others 7'h7F, one beat 7'h7F with in_last -> out_acc[0]=-7, others=+7, out_bits[0]=0, others=1 (macro off).
REQ-033 Hold out_ready=0 for 5 cycles after out_valid -> in_ready=0, outputs stable; raise out_ready with a new beat -> beat accepted in that cycle.
REQ-034 MAX_BEATS=4, 5 beats without in_last -> close after beat 4 with out_count=4, out_ovf=1; beat 5 starts the next window.
REQ-035 clr after 2 beats, then one 7'h7F beat with in_last (all weights 7'h7F) -> out_acc=7, out_count=1; with BNN_THRESH_EN, thr=8 -> out_bits=0.
